pll_cfg_seq: RTL and testbench
==============================

PLL_CFG_SEQ -- requirements
Module: pll_cfg_seq

Interface
REQ-001 SHALL provide parameters (name, default, meaning):
- M_NTSC, 32'h00000C0C: M counter word for profile 0.
- K_NTSC, 32'd234263494: fractional K word for profile 0.
- M_PAL, 32'h00000C0C: M counter word for profile 1.
- K_PAL, 32'd1288490189: K word for profile 1.
- M_DENDY, 32'h00000D0C: M counter word for profile 2.
- K_DENDY, 32'd858993459: K word for profile 2.
- LOCK_TO, 65535: maximum lock-wait cycles.
REQ-002 SHALL provide ports (name, direction, width, meaning):
- clk, in, 1: sole clock.
- rst, in, 1: synchronous active-high reset.
- cfg_req, in, 1: one-cycle reconfiguration request.
- cfg_profile, in, 2: 0=NTSC, 1=PAL, 2=Dendy, 3=treated as 0.
- cfg_busy, out, 1: sequence in progress.
- cfg_done, out, 1: one-cycle completion pulse.
- cfg_err, out, 1: sticky failure flag.
- pll_locked, in, 1: PLL lock, already synchronised to clk.
- mgmt_address, out, 6: reconfig-core register address.
- mgmt_write, out, 1: write strobe.
- mgmt_read, out, 1: read strobe.
- mgmt_writedata, out, 32: write data.
- mgmt_readdata, in, 32: read data.
- mgmt_waitrequest, in, 1: slave stall.
REQ-003 SHALL use clock clk and synchronous active-high reset rst, with no other clock or asynchronous logic.

Function
REQ-004 SHALL implement the states IDLE, WR_MODE, WR_M, WR_K, WR_START, RD_M, WAIT_LOCK and DONE.
REQ-005 SHALL, in IDLE on cfg_req, latch cfg_profile and go to WR_MODE with cfg_busy=1 and cfg_err cleared on the next cycle.
REQ-006 SHALL skip all writes when the latched profile equals the last successfully applied profile and cfg_err=0, pulsing cfg_done 1 cycle after cfg_req.
REQ-007 SHALL perform these writes in order:
- WR_MODE: addr 0x00, data 0.
- WR_M: addr 0x04, data M_x.
- WR_K: addr 0x07, data K_x.
- WR_START: addr 0x02, data 0.
REQ-008 SHALL hold mgmt_write, mgmt_address and mgmt_writedata stable while mgmt_waitrequest=1, and advance the cycle after mgmt_write=1 and mgmt_waitrequest=0.
REQ-009 SHALL never assert mgmt_write and mgmt_read in the same cycle, and SHALL deassert both outside write/read states.
REQ-010 SHALL, in WAIT_LOCK, count cycles from 0 and go to DONE when pll_locked=1 is seen at least 4 cycles after WR_START completes.
REQ-011 SHALL, when the counter reaches LOCK_TO without lock, set cfg_err=1, pulse cfg_done and return to IDLE without updating the applied profile.
REQ-012 SHALL, in DONE, record the applied profile, pulse cfg_done for 1 cycle, drop cfg_busy on the same cycle and return to IDLE.
REQ-013 SHALL keep a 1-deep pending slot for cfg_req while busy; a later request SHALL overwrite the pending profile, and the slot SHALL be serviced on the cycle after DONE or timeout.
REQ-014 SHALL, when cfg_req arrives in the same cycle as completion, treat it as pending with no lost request.

Reset
REQ-015 SHALL on rst, from any state including mid-transfer, set state=IDLE, cfg_busy=0, cfg_done=0, cfg_err=0, mgmt_write=0, mgmt_read=0, mgmt_address=0, mgmt_writedata=0, clear the pending slot, and mark the applied profile invalid.
REQ-016 SHALL hold all outputs at reset values while rst=1 regardless of mgmt_waitrequest.

Configuration
REQ-017 SHALL, with PLL_CFG_READBACK_EN defined, enter RD_M after WR_K: read addr 0x04, hold mgmt_read until waitrequest=0, and compare mgmt_readdata to M_x.
REQ-018 SHALL on a readback mismatch set cfg_err=1, pulse cfg_done, skip WR_START and return to IDLE.
REQ-019 SHALL, without PLL_CFG_READBACK_EN, go directly WR_K to WR_START, with RD_M unreachable and mgmt_read tied 0.

Verification
REQ-020 SHALL cover:
- Profile 1 request, waitrequest=0, lock 10 cycles after start -> writes 0x00/0, 0x04/M_PAL, 0x07/K_PAL, 0x02/0, then cfg_done 1 pulse, cfg_err=0.
- Waitrequest held 5 cycles on WR_M -> address and data stable for 6 cycles and no extra write.
- Lock never asserts, LOCK_TO=100 -> cfg_err=1 and cfg_done around 100 cycles after start; a same-profile re-request rewrites everything.
- Profile 2 request then profile 0 request while busy -> the Dendy sequence completes, then the NTSC sequence runs immediately.
- rst during WR_K with waitrequest=1 -> mgmt_write=0 next cycle and all outputs at reset values.
- With PLL_CFG_READBACK_EN, readdata = M_x ^ 1 -> cfg_err=1 and no 0x02 write.

Source files
------------

// File: rtl/pll_cfg_seq.sv
// PLL reconfiguration sequencer: writes mode, M, K and start to the reconfig core, then waits for lock.
// Optional: define PLL_CFG_READBACK_EN to read M back and compare it before issuing start.
module pll_cfg_seq #(
  parameter logic [31:0] M_NTSC  = 32'h00000C0C,
  parameter logic [31:0] K_NTSC  = 32'd234263494,
  parameter logic [31:0] M_PAL   = 32'h00000C0C,
  parameter logic [31:0] K_PAL   = 32'd1288490189,
  parameter logic [31:0] M_DENDY = 32'h00000D0C,
  parameter logic [31:0] K_DENDY = 32'd858993459,
  parameter int unsigned LOCK_TO = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_req,
  input  logic [1:0]  cfg_profile,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_err,
  input  logic        pll_locked,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic        mgmt_read,
  output logic [31:0] mgmt_writedata,
  input  logic [31:0] mgmt_readdata,
  input  logic        mgmt_waitrequest
);
  typedef enum logic [2:0] {
    S_IDLE, S_WR_MODE, S_WR_M, S_WR_K, S_WR_START, S_RD_M, S_WAIT_LOCK, S_DONE
  } state_e;

  state_e      state_q;
  logic [1:0]  prof_q, app_p_q, pend_p_q;
  logic        app_v_q, pend_v_q;
  logic        busy_q, done_q, err_q, wr_q;
  logic [5:0]  addr_q;
  logic [31:0] wdata_q, cnt_q;
  logic [1:0]  req_p_d;
  logic        req_v_d, skip_d;

  function automatic logic [1:0] norm(input logic [1:0] p);
    return (p == 2'd3) ? 2'd0 : p;
  endfunction

  function automatic logic [31:0] m_of(input logic [1:0] p);
    case (p)
      2'd1:    return M_PAL;
      2'd2:    return M_DENDY;
      default: return M_NTSC;
    endcase
  endfunction

  function automatic logic [31:0] k_of(input logic [1:0] p);
    case (p)
      2'd1:    return K_PAL;
      2'd2:    return K_DENDY;
      default: return K_NTSC;
    endcase
  endfunction

  // A fresh request in IDLE outranks whatever is sitting in the pending slot
  assign req_v_d = cfg_req | pend_v_q;
  assign req_p_d = cfg_req ? norm(cfg_profile) : pend_p_q;
  assign skip_d  = app_v_q && (req_p_d == app_p_q) && !err_q;

`ifdef PLL_CFG_READBACK_EN
  logic rd_q;
  assign mgmt_read = rd_q;
`else
  logic unused_rd;
  assign mgmt_read = 1'b0;
  assign unused_rd = ^mgmt_readdata;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      prof_q   <= 2'd0;
      app_p_q  <= 2'd0;
      app_v_q  <= 1'b0;
      pend_p_q <= 2'd0;
      pend_v_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= 6'h00;
      wdata_q  <= '0;
      cnt_q    <= '0;
`ifdef PLL_CFG_READBACK_EN
      rd_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      // Requests while busy (including the completion cycle) land in the pending slot
      if (state_q != S_IDLE && cfg_req) begin
        pend_v_q <= 1'b1;
        pend_p_q <= norm(cfg_profile);
      end
      case (state_q)
        S_IDLE: if (req_v_d) begin
          pend_v_q <= 1'b0;
          prof_q   <= req_p_d;
          if (skip_d) begin
            done_q <= 1'b1;
          end else begin
            state_q <= S_WR_MODE;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
            wr_q    <= 1'b1;
            addr_q  <= 6'h00;
            wdata_q <= '0;
          end
        end
        S_WR_MODE: if (!mgmt_waitrequest) begin
          state_q <= S_WR_M;
          addr_q  <= 6'h04;
          wdata_q <= m_of(prof_q);
        end
        S_WR_M: if (!mgmt_waitrequest) begin
          state_q <= S_WR_K;
          addr_q  <= 6'h07;
          wdata_q <= k_of(prof_q);
        end
        S_WR_K: if (!mgmt_waitrequest) begin
`ifdef PLL_CFG_READBACK_EN
          state_q <= S_RD_M;
          wr_q    <= 1'b0;
          rd_q    <= 1'b1;
          addr_q  <= 6'h04;
          wdata_q <= '0;
`else
          state_q <= S_WR_START;
          addr_q  <= 6'h02;
          wdata_q <= '0;
`endif
        end
`ifdef PLL_CFG_READBACK_EN
        S_RD_M: if (!mgmt_waitrequest) begin
          rd_q <= 1'b0;
          if (mgmt_readdata == m_of(prof_q)) begin
            state_q <= S_WR_START;
            wr_q    <= 1'b1;
            addr_q  <= 6'h02;
          end else begin
            state_q <= S_IDLE;
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            addr_q  <= 6'h00;
          end
        end
`endif
        S_WR_START: if (!mgmt_waitrequest) begin
          state_q <= S_WAIT_LOCK;
          wr_q    <= 1'b0;
          addr_q  <= 6'h00;
          wdata_q <= '0;
          cnt_q   <= '0;
        end
        S_WAIT_LOCK: begin
          // Lock is ignored for the first few cycles so a stale lock from the old setting cannot finish us
          if (pll_locked && cnt_q >= 32'd4) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            app_v_q <= 1'b1;
            app_p_q <= prof_q;
          end else if (cnt_q == LOCK_TO) begin
            state_q <= S_IDLE;
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cfg_busy       = busy_q;
  assign cfg_done       = done_q;
  assign cfg_err        = err_q;
  assign mgmt_write     = wr_q;
  assign mgmt_address   = addr_q;
  assign mgmt_writedata = wdata_q;

endmodule

// File: tb/tb_pll_cfg_seq.sv
// Randomized bench for pll_cfg_seq: a transaction-level model predicts the write list,
// done/err outcome and timing window of each reconfiguration request.
module tb_pll_cfg_seq;
  localparam int LT = 100;
  localparam logic [31:0] MW [3] = '{32'h00000C0C, 32'h00000C0C, 32'h00000D0C};
  localparam logic [31:0] KW [3] = '{32'd234263494, 32'd1288490189, 32'd858993459};

  logic        clk = 1'b0;
  logic        rst, cfg_req, cfg_busy, cfg_done, cfg_err, pll_locked;
  logic [1:0]  cfg_profile;
  logic [5:0]  mgmt_address;
  logic        mgmt_write, mgmt_read, mgmt_waitrequest;
  logic [31:0] mgmt_writedata, mgmt_readdata;

  pll_cfg_seq #(.LOCK_TO(LT)) dut (
    .clk(clk), .rst(rst), .cfg_req(cfg_req), .cfg_profile(cfg_profile),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err), .pll_locked(pll_locked),
    .mgmt_address(mgmt_address), .mgmt_write(mgmt_write), .mgmt_read(mgmt_read),
    .mgmt_writedata(mgmt_writedata), .mgmt_readdata(mgmt_readdata),
    .mgmt_waitrequest(mgmt_waitrequest)
  );

  always #5 clk = ~clk;

  int          n_cmp, n_err, cyc;
  logic [37:0] exp_q[$], obs_q[$];
  int          obs_cyc[$];
  logic [31:0] mem [64];
  int          done_cnt, done_cyc, first_done, start_cyc, lock_dly, since, m_cyc, hold_m_left;
  bit          done_err, lk_on, force_wr, rand_wr, corrupt, prev_hold;
  logic [5:0]  p_addr;
  logic [31:0] p_data;
  bit          m_app_v, m_err;
  int          m_app_p;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: sample outputs after the edge, then drive slave/PLL responses for the next edge
  task automatic step();
    bit acc;
    @(posedge clk); #1;
    cyc++;
    chk("rw_excl", 64'(mgmt_write & mgmt_read), 64'd0);
    if (prev_hold && !rst) begin
      chk("hold_wr", 64'(mgmt_write), 64'd1);
      chk("hold_addr", 64'(mgmt_address), 64'(p_addr));
      chk("hold_data", 64'(mgmt_writedata), 64'(p_data));
    end
    if (cfg_done) begin
      done_cnt++;
      if (done_cnt == 1) first_done = cyc;
      done_cyc = cyc;
      done_err = cfg_err;
    end
    if (mgmt_write && mgmt_address == 6'h04) m_cyc++;
    if (force_wr) mgmt_waitrequest = 1'b1;
    else if (mgmt_write && mgmt_address == 6'h04 && hold_m_left > 0) begin
      mgmt_waitrequest = 1'b1;
      hold_m_left--;
    end else if (rand_wr) mgmt_waitrequest = ($urandom_range(0, 2) == 0);
    else mgmt_waitrequest = 1'b0;
    mgmt_readdata = mem[mgmt_address] ^ {31'd0, corrupt};
    acc = mgmt_write && !mgmt_waitrequest && !rst;
    if (acc) begin
      obs_q.push_back({mgmt_address, mgmt_writedata});
      obs_cyc.push_back(cyc);
      mem[mgmt_address] = mgmt_writedata;
    end
    if (acc && mgmt_address == 6'h00) lk_on = 1'b0;
    else if (acc && mgmt_address == 6'h02) begin
      lk_on = 1'b1; since = 0; start_cyc = cyc;
    end else if (lk_on) since++;
    pll_locked = lk_on && lock_dly >= 0 && since >= lock_dly;
    prev_hold = mgmt_write && mgmt_waitrequest && !rst;
    p_addr = mgmt_address;
    p_data = mgmt_writedata;
  endtask

  // Reference: what one request should produce given applied profile / error history
  task automatic model_req(input int p, input int ld, input bit bad_rb, output bit skip, output bit eerr);
    int q;
    q = (p == 3) ? 0 : p;
    skip = m_app_v && q == m_app_p && !m_err;
    eerr = 1'b0;
    if (skip) return;
    exp_q.push_back({6'h00, 32'd0});
    exp_q.push_back({6'h04, MW[q]});
    exp_q.push_back({6'h07, KW[q]});
    if (bad_rb) eerr = 1'b1;
    else begin
      exp_q.push_back({6'h02, 32'd0});
      eerr = (ld < 0);
    end
    m_err = eerr;
    if (!eerr) begin m_app_v = 1'b1; m_app_p = q; end
  endtask

  task automatic cmp_writes(input string tag);
    chk({tag, "_nwr"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk($sformatf("%s_wr%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
  endtask

  task automatic clear_obs();
    exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    done_cnt = 0;
  endtask

  task automatic run_txn(input int p, input int ld);
    bit skip, eerr;
    int req_cyc, g, d, hi;
    clear_obs();
    lock_dly = ld;
    model_req(p, ld, corrupt, skip, eerr);
    req_cyc = cyc;
    cfg_profile = 2'(p); cfg_req = 1'b1;
    step();
    cfg_req = 1'b0;
    chk("busy_set", 64'(cfg_busy), 64'(!skip));
    chk("err_clr", 64'(cfg_err), 64'd0);
    g = 0;
    while (done_cnt == 0 && g < LT + 300) begin step(); g++; end
    chk("done_seen", 64'(done_cnt), 64'd1);
    chk("done_err", 64'(done_err), 64'(eerr));
    d = done_cyc - start_cyc;
    if (skip) chk("skip_lat", 64'(done_cyc - req_cyc), 64'd1);
    else if (ld < 0 && !corrupt) chk("to_lat", 64'(d >= LT && d <= LT + 4), 64'd1);
    else if (!corrupt) begin
      hi = ((ld < 4) ? 4 : ld) + 3;
      chk("lock_lat", 64'(d >= ld + 1 && d <= hi), 64'd1);
    end
    repeat (3) step();
    chk("done_once", 64'(done_cnt), 64'd1);
    chk("busy_idle", 64'(cfg_busy), 64'd0);
    chk("err_sticky", 64'(cfg_err), 64'(eerr));
    cmp_writes("wr");
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_busy"}, 64'(cfg_busy), 64'd0);
    chk({tag, "_done"}, 64'(cfg_done), 64'd0);
    chk({tag, "_err"}, 64'(cfg_err), 64'd0);
    chk({tag, "_wr"}, 64'(mgmt_write), 64'd0);
    chk({tag, "_rd"}, 64'(mgmt_read), 64'd0);
    chk({tag, "_addr"}, 64'(mgmt_address), 64'd0);
    chk({tag, "_wdata"}, 64'(mgmt_writedata), 64'd0);
  endtask

  initial begin
    bit sk, e;
    int g, p;
    rst = 1'b1; cfg_req = 1'b0; cfg_profile = 2'd0; pll_locked = 1'b0;
    mgmt_waitrequest = 1'b0; mgmt_readdata = '0;
    n_cmp = 0; n_err = 0; cyc = 0; lock_dly = -1; since = 0; lk_on = 1'b0;
    force_wr = 1'b0; rand_wr = 1'b0; corrupt = 1'b0; prev_hold = 1'b0;
    hold_m_left = 0; m_cyc = 0; m_app_v = 1'b0; m_err = 1'b0; m_app_p = 0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    repeat (3) step();
    chk_reset_outs("por");
    rst = 1'b0;
    step();

    // PAL with lock 10 cycles after start
    run_txn(1, 10);
    // Waitrequest held 5 cycles on the M write
    hold_m_left = 5; m_cyc = 0;
    run_txn(0, 7);
    chk("m_hold_cyc", 64'(m_cyc), 64'd6);
    // Timeout, then the same profile is rewritten, then skipped once applied
    run_txn(2, -1);
    run_txn(2, 6);
    run_txn(2, 6);

    // Reset in the middle of a stalled K write
    clear_obs(); lock_dly = -1;
    cfg_profile = 2'd1; cfg_req = 1'b1; step(); cfg_req = 1'b0;
    g = 0;
    while (!(mgmt_write && mgmt_address == 6'h07) && g < 50) begin step(); g++; end
    chk("reach_wrk", 64'(mgmt_write && mgmt_address == 6'h07), 64'd1);
    force_wr = 1'b1;
    step();
    rst = 1'b1;
    step(); chk_reset_outs("rst1");
    step(); chk_reset_outs("rst2");
    rst = 1'b0; force_wr = 1'b0;
    m_app_v = 1'b0; m_err = 1'b0; lk_on = 1'b0; pll_locked = 1'b0;
    step();
    run_txn(1, 5);

    // Dendy, then NTSC arriving while busy: both run back to back
    clear_obs(); lock_dly = 6;
    model_req(2, 6, 1'b0, sk, e);
    model_req(0, 6, 1'b0, sk, e);
    cfg_profile = 2'd2; cfg_req = 1'b1; step(); cfg_req = 1'b0;
    repeat (3) step();
    chk("busy_pend", 64'(cfg_busy), 64'd1);
    cfg_profile = 2'd0; cfg_req = 1'b1; step(); cfg_req = 1'b0;
    g = 0;
    while (done_cnt < 2 && g < 400) begin step(); g++; end
    chk("pend_done", 64'(done_cnt), 64'd2);
    cmp_writes("pend");
    if (obs_q.size() > 4) chk("pend_gap", 64'(obs_cyc[4] - first_done <= 3), 64'd1);
    repeat (3) step();

`ifdef PLL_CFG_READBACK_EN
    corrupt = 1'b1;
    run_txn(2, 5);
    corrupt = 1'b0;
`endif

    rand_wr = 1'b1;
    for (int i = 0; i < 12; i++) begin
      p = $urandom_range(0, 3);
      run_txn(p, ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 20)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
